// File: rtl/pwm_bank_pkg.sv
// ----------------------------------------------------------------------------
// pwm_bank_pkg
// Shared definitions for the PWM bank: CTRL register bit positions, register
// address offsets above the threshold window, the write-decode select type and
// a helper that turns an offset into an absolute register address.
// No ports (package).
// ----------------------------------------------------------------------------
package pwm_bank_pkg;

   // CTRL register fields
   localparam int CTRL_EN_BIT     = 32'sd0;
   localparam int CTRL_COMMIT_BIT = 32'sd1;

   // Register offsets relative to num_pwm (thresholds occupy 0..num_pwm-1)
   localparam int REG_PERIOD_OFS  = 32'sd0;
   localparam int REG_CTRL_OFS    = 32'sd1;
   localparam int REG_POL_OFS     = 32'sd2;

   // Which register a write targets
   typedef enum logic [2:0] {
      REG_THRES  = 3'd0,
      REG_PERIOD = 3'd1,
      REG_CTRL   = 3'd2,
      REG_POL    = 3'd3,
      REG_NONE   = 3'd4
   } reg_sel_e;

   // Absolute address of a register that sits above the threshold window
   function automatic int reg_addr(input int num_ch, input int ofs);
      return num_ch + ofs;
   endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// ----------------------------------------------------------------------------
// pwm_bank_if
// Register-write port of the PWM bank (valid/ready, one write per accepted
// cycle).
//   wr_valid  master->slave  write request
//   wr_ready  slave->master  write accepted when wr_valid && wr_ready
//   wr_addr   master->slave  register address (aw bits)
//   wr_data   master->slave  write data (pwm_width bits)
// Modports: master (command decoder side), slave (pwm_bank side).
// ----------------------------------------------------------------------------
interface pwm_bank_if #(
   parameter int aw        = 4,
   parameter int pwm_width = 16
);

   logic                 wr_valid;
   logic                 wr_ready;
   logic [aw-1:0]        wr_addr;
   logic [pwm_width-1:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/pwm_bank_counter.sv
// ----------------------------------------------------------------------------
// pwm_bank_counter
// Shared period counter of the PWM bank. Counts 0..period while enabled and is
// held at 0 while disabled. Flags the wrap cycle (cnt == period), produces a
// registered one-cycle period_start pulse in the cycle the counter returns to
// 0, and issues the strobe that copies shadow registers into the active set.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   en             counter enable (CTRL.en)
//   pending        a commit is waiting to be applied
//   period         active period (last count value of a period)
//   cnt            current count
//   wrap           this cycle is the last one of the period
//   apply          copy shadow -> active on this clock edge
//   period_start   registered pulse, high while cnt sits at 0 after a wrap
// ----------------------------------------------------------------------------
module pwm_bank_counter
   import pwm_bank_pkg::*;
#(
   parameter int pwm_width = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 pending,
   input  logic [pwm_width-1:0] period,
   output logic [pwm_width-1:0] cnt,
   output logic                 wrap,
   output logic                 apply,
   output logic                 period_start
);

   localparam logic [pwm_width-1:0] CNT_ZERO = {pwm_width{1'b0}};
   localparam logic [pwm_width-1:0] CNT_ONE  = {{(pwm_width-1){1'b0}}, 1'b1};

   logic [pwm_width-1:0] cnt_r;
   logic                 period_start_r;
   logic                 wrap_s;
   logic                 apply_s;

   assign wrap_s = en & (cnt_r == period);

   // Commit strobe: at the period boundary when running, otherwise right away
   always_comb begin
      apply_s = 1'b0;
      if (!pending) begin
         apply_s = 1'b0;
      end else if (en) begin
         apply_s = wrap_s;
      end else begin
         apply_s = 1'b1;
      end
   end

   // Period counter and period_start pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r          <= CNT_ZERO;
         period_start_r <= 1'b0;
      end else if (!en) begin
         cnt_r          <= CNT_ZERO;
         period_start_r <= 1'b0;
      end else if (wrap_s) begin
         // period == 0 lands here every cycle: cnt stays 0, pulse stays high
         cnt_r          <= CNT_ZERO;
         period_start_r <= 1'b1;
      end else begin
         cnt_r          <= cnt_r + CNT_ONE;
         period_start_r <= 1'b0;
      end
   end

   assign cnt          = cnt_r;
   assign wrap         = wrap_s;
   assign apply        = apply_s;
   assign period_start = period_start_r;

endmodule

// File: rtl/pwm_bank.sv
// ----------------------------------------------------------------------------
// pwm_bank
// Multi-channel PWM generator with one shared programmable period and
// double-buffered per-channel thresholds. Register writes land in shadow
// registers; a CTRL commit copies every shadow value into the active set at
// once, at a period boundary while running, so outputs never change shape
// mid-period. While a commit waits, the write port stalls (wr_ready=0).
// Register map (aw = $clog2(num_pwm+3)):
//   0..num_pwm-1  thres[i]  channel i is high while cnt < thres[i]
//   num_pwm       PERIOD    last count value of a period
//   num_pwm+1     CTRL      bit0 en (takes effect immediately), bit1 commit
//   num_pwm+2     POL       per-channel output inversion, only with
//                           PWM_POLARITY_EN defined; otherwise dropped
//   others        accepted and dropped
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   bus             pwm_bank_if.slave register-write port
//   pwm_out         registered PWM outputs, one cycle after the counter
//   period_start    one-cycle pulse when the counter restarts from a wrap
//   commit_pending  commit requested, not yet applied
// Build option: PWM_POLARITY_EN adds the double-buffered POL register.
// ----------------------------------------------------------------------------
module pwm_bank
   import pwm_bank_pkg::*;
#(
   parameter int pwm_width = 16,
   parameter int num_pwm   = 12
) (
   input  logic               clk,
   input  logic               rst,
   pwm_bank_if.slave          bus,
   output logic [num_pwm-1:0] pwm_out,
   output logic               period_start,
   output logic               commit_pending
);

   localparam int aw = $clog2(num_pwm + 3);

   localparam logic [aw-1:0] ADDR_NUM_CH = aw'(num_pwm);
   localparam logic [aw-1:0] ADDR_PERIOD = aw'(reg_addr(num_pwm, REG_PERIOD_OFS));
   localparam logic [aw-1:0] ADDR_CTRL   = aw'(reg_addr(num_pwm, REG_CTRL_OFS));
   localparam logic [aw-1:0] ADDR_POL    = aw'(reg_addr(num_pwm, REG_POL_OFS));

   localparam logic [pwm_width-1:0] VAL_ZERO = {pwm_width{1'b0}};
   localparam logic [pwm_width-1:0] VAL_ONES = {pwm_width{1'b1}};

   // Write decode
   logic     wr_fire_s;
   reg_sel_e reg_sel_s;
   logic     commit_req_s;

   // Control state
   logic en_r;
   logic pending_r;
   logic pending_nxt_s;
   logic wr_ready_r;

   // Shadow / active register sets
   logic [pwm_width-1:0] shadow_period_r;
   logic [pwm_width-1:0] active_period_r;
   logic [pwm_width-1:0] shadow_thres_r [num_pwm];
   logic [pwm_width-1:0] active_thres_r [num_pwm];
   logic [num_pwm-1:0]   pol_active_s;

   // Counter interface and comparators
   logic [pwm_width-1:0] cnt_s;
   logic                 wrap_s;
   logic                 apply_s;
   logic                 period_start_s;
   logic [num_pwm-1:0]   raw_s;
   logic [num_pwm-1:0]   pwm_out_r;

   assign wr_fire_s    = bus.wr_valid & wr_ready_r;
   assign bus.wr_ready = wr_ready_r;

   // Address decode of the presented write
   always_comb begin
      reg_sel_s = REG_NONE;
      if (bus.wr_addr < ADDR_NUM_CH) begin
         reg_sel_s = REG_THRES;
      end else if (bus.wr_addr == ADDR_PERIOD) begin
         reg_sel_s = REG_PERIOD;
      end else if (bus.wr_addr == ADDR_CTRL) begin
         reg_sel_s = REG_CTRL;
      end else if (bus.wr_addr == ADDR_POL) begin
         reg_sel_s = REG_POL;
      end else begin
         reg_sel_s = REG_NONE;
      end
   end

   assign commit_req_s = wr_fire_s & (reg_sel_s == REG_CTRL) & bus.wr_data[CTRL_COMMIT_BIT];

   // Pending flag: set by a commit write, cleared when the copy happens.
   // Both cannot coincide because a commit is only accepted while idle.
   always_comb begin
      pending_nxt_s = pending_r;
      if (commit_req_s) begin
         pending_nxt_s = 1'b1;
      end else if (apply_s) begin
         pending_nxt_s = 1'b0;
      end else begin
         pending_nxt_s = pending_r;
      end
   end

   // Control register, pending flag and the registered ready output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_r       <= 1'b0;
         pending_r  <= 1'b0;
         wr_ready_r <= 1'b1;
      end else begin
         pending_r  <= pending_nxt_s;
         wr_ready_r <= ~pending_nxt_s;
         if (wr_fire_s && (reg_sel_s == REG_CTRL)) begin
            en_r <= bus.wr_data[CTRL_EN_BIT];
         end
      end
   end

   // Shadow writes and the atomic shadow -> active copy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_period_r <= VAL_ONES;
         active_period_r <= VAL_ONES;
         for (int i = 0; i < num_pwm; i++) begin
            shadow_thres_r[i] <= VAL_ZERO;
            active_thres_r[i] <= VAL_ZERO;
         end
      end else begin
         if (wr_fire_s && (reg_sel_s == REG_PERIOD)) begin
            shadow_period_r <= bus.wr_data;
         end
         for (int i = 0; i < num_pwm; i++) begin
            if (wr_fire_s && (reg_sel_s == REG_THRES) && (bus.wr_addr == aw'(i))) begin
               shadow_thres_r[i] <= bus.wr_data;
            end
         end
         if (apply_s) begin
            active_period_r <= shadow_period_r;
            for (int i = 0; i < num_pwm; i++) begin
               active_thres_r[i] <= shadow_thres_r[i];
            end
         end
      end
   end

`ifdef PWM_POLARITY_EN
   logic [num_pwm-1:0] shadow_pol_r;
   logic [num_pwm-1:0] active_pol_r;

   // POL register, double-buffered exactly like the thresholds
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_pol_r <= {num_pwm{1'b0}};
         active_pol_r <= {num_pwm{1'b0}};
      end else begin
         if (wr_fire_s && (reg_sel_s == REG_POL)) begin
            shadow_pol_r <= bus.wr_data[num_pwm-1:0];
         end
         if (apply_s) begin
            active_pol_r <= shadow_pol_r;
         end
      end
   end

   assign pol_active_s = active_pol_r;
`else
   assign pol_active_s = {num_pwm{1'b0}};
`endif

   pwm_bank_counter #(
      .pwm_width (pwm_width)
   ) u_counter (
      .clk          (clk),
      .rst          (rst),
      .en           (en_r),
      .pending      (pending_r),
      .period       (active_period_r),
      .cnt          (cnt_s),
      .wrap         (wrap_s),
      .apply        (apply_s),
      .period_start (period_start_s)
   );

   // Per-channel unsigned compare; a disabled bank gives raw 0 on every channel
   always_comb begin
      raw_s = {num_pwm{1'b0}};
      for (int i = 0; i < num_pwm; i++) begin
         raw_s[i] = en_r & (cnt_s < active_thres_r[i]);
      end
   end

   // Output register: polarity applied after the compare
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_out_r <= {num_pwm{1'b0}};
      end else begin
         pwm_out_r <= raw_s ^ pol_active_s;
      end
   end

   assign pwm_out        = pwm_out_r;
   assign period_start   = period_start_s;
   assign commit_pending = pending_r;

endmodule

// File: tb/tb_pwm_bank.sv
// ----------------------------------------------------------------------------
// tb_pwm_bank
// Directed and randomized register writes against a behavioural model of the
// PWM bank. The model keeps the position inside the current period as plain
// modular arithmetic, whole configuration sets (shadow/active) as arrays, and
// predicts every registered output one cycle after the position it reflects.
// ----------------------------------------------------------------------------
module tb_pwm_bank;

   localparam int W        = 16;
   localparam int N        = 12;
   localparam int AW       = $clog2(N + 3);
   localparam int A_PERIOD = N;
   localparam int A_CTRL   = N + 1;
   localparam int A_POL    = N + 2;
`ifdef PWM_POLARITY_EN
   localparam bit POL_EN = 1'b1;
`else
   localparam bit POL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] pwm_out;
   logic         period_start;
   logic         commit_pending;

   pwm_bank_if #(.aw(AW), .pwm_width(W)) bus ();

   pwm_bank #(.pwm_width(W), .num_pwm(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .pwm_out        (pwm_out),
      .period_start   (period_start),
      .commit_pending (commit_pending)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model
   int           m_phase;
   int           m_period_act, m_period_sh;
   int           m_thres_act [N];
   int           m_thres_sh  [N];
   logic [N-1:0] m_pol_act, m_pol_sh;
   bit           m_en, m_pending, m_pstart, m_fired;
   logic [N-1:0] m_out;

   int hi0, hi1, hi2, ps, pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s timed out", tag);
   endtask

   function automatic void model_reset();
      m_phase      = 0;
      m_period_act = 65535;
      m_period_sh  = 65535;
      for (int i = 0; i < N; i++) begin
         m_thres_act[i] = 0;
         m_thres_sh[i]  = 0;
      end
      m_pol_act = '0;
      m_pol_sh  = '0;
      m_en      = 1'b0;
      m_pending = 1'b0;
      m_pstart  = 1'b0;
      m_out     = '0;
      m_fired   = 1'b0;
   endfunction

   // One clock edge: outputs from the pre-edge position, then advance state
   function automatic void model_edge();
      logic [W-1:0] d = bus.wr_data;
      int  a       = int'(bus.wr_addr);
      bit  fire    = bus.wr_valid && !m_pending;
      bit  at_end  = m_en && (m_phase == m_period_act);
      bit  take    = m_pending && (!m_en || at_end);
      for (int i = 0; i < N; i++)
         m_out[i] = (m_en && (m_phase < m_thres_act[i])) ^ m_pol_act[i];
      m_pstart = at_end;
      m_phase  = m_en ? (m_phase + 1) % (m_period_act + 1) : 0;
      if (take) begin
         m_period_act = m_period_sh;
         m_thres_act  = m_thres_sh;
         m_pol_act    = m_pol_sh;
         m_pending    = 1'b0;
      end
      m_fired = fire;
      if (fire) begin
         if (a < N) m_thres_sh[a] = int'(d);
         else if (a == A_PERIOD) m_period_sh = int'(d);
         else if (a == A_CTRL) begin
            m_en = d[0];
            if (d[1]) m_pending = 1'b1;
         end
`ifdef PWM_POLARITY_EN
         else if (a == A_POL) m_pol_sh = d[N-1:0];
`endif
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst) model_reset();
      else model_edge();
      #1;
      chk("pwm_out", 32'(pwm_out), 32'(m_out));
      chk("period_start", 32'(period_start), 32'(m_pstart));
      chk("commit_pending", 32'(commit_pending), 32'(m_pending));
      chk("wr_ready", 32'(bus.wr_ready), 32'(!m_pending));
   endtask

   task automatic wr(input int addr, input int data);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'(addr);
      bus.wr_data  = W'(data);
      m_fired      = 1'b0;
      for (int k = 0; k < 200 && !m_fired; k++) tick();
      if (!m_fired) timeout("wr_accept");
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100 && m_pending; k++) tick();
      if (m_pending) timeout("wait_idle");
   endtask

   task automatic wait_phase(input int p);
      for (int k = 0; k < 100 && !(m_en && m_phase == p); k++) tick();
      if (!(m_en && m_phase == p)) timeout("wait_phase");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      model_reset();

      // Reset and idle
      repeat (3) tick();
      chk("rst_pwm_out", 32'(pwm_out), 32'd0);
      chk("rst_ready", 32'(bus.wr_ready), 32'd1);
      #2 rst = 1'b1;
      repeat (20) tick();

      // Basic duty: period 9, ch0=3, ch1=0, ch2=15
      wr(A_PERIOD, 9);
      wr(0, 3);
      wr(1, 0);
      wr(2, 15);
      for (int i = 3; i < N; i++) wr(i, int'($urandom_range(0, 12)));
      wr(A_CTRL, 2);
      wait_idle();
      wr(A_CTRL, 1);
      repeat (10) tick();
      hi0 = 0; hi1 = 0; hi2 = 0; ps = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         hi0 += int'(pwm_out[0]);
         hi1 += int'(pwm_out[1]);
         hi2 += int'(pwm_out[2]);
         ps  += int'(period_start);
      end
      chk("duty_ch0", 32'(hi0), 32'd9);
      chk("duty_ch1", 32'(hi1), 32'd0);
      chk("duty_ch2", 32'(hi2), 32'd30);
      chk("period_start_rate", 32'(ps), 32'd3);

      // Mid-period commit: thres0=7 at cnt 3, commit at cnt 4
      wait_phase(3);
      wr(0, 7);
      wr(A_CTRL, 3);
      pend = 0;
      for (int k = 0; k < 40 && commit_pending; k++) begin
         pend++;
         tick();
      end
      chk("mid_commit_pending_len", 32'(pend), 32'd5);
      hi0 = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         hi0 += int'(pwm_out[0]);
      end
      chk("mid_commit_new_duty", 32'(hi0), 32'd7);

      // Commit exactly on the wrap cycle waits one full period
      wr(0, 5);
      wait_phase(9);
      wr(A_CTRL, 3);
      pend = 0; hi0 = 0;
      for (int k = 0; k < 40 && commit_pending; k++) begin
         pend++;
         hi0 += int'(pwm_out[0]);
         tick();
      end
      chk("wrap_commit_pending_len", 32'(pend), 32'd10);
      chk("wrap_commit_old_duty", 32'(hi0), 32'd7);
      hi0 = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         hi0 += int'(pwm_out[0]);
      end
      chk("wrap_commit_new_duty", 32'(hi0), 32'd5);

      // period = 0: pulse every cycle, thres>=1 constantly high
      wr(A_PERIOD, 0);
      wr(A_CTRL, 3);
      wait_idle();
      repeat (3) tick();
      hi0 = 0; ps = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         hi0 += int'(pwm_out[0]);
         ps  += int'(period_start);
      end
      chk("period0_pulses", 32'(ps), 32'd5);
      chk("period0_ch0_high", 32'(hi0), 32'd5);

      // Randomized writes, including unused addresses and random CTRL bits
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            int a;
            int d;
            a = int'($urandom_range(0, (1 << AW) - 1));
            if (a < N) d = int'($urandom_range(0, 20));
            else if (a == A_PERIOD) d = int'($urandom_range(0, 15));
            else if (a == A_CTRL) d = int'($urandom_range(0, 15));
            else d = int'($urandom_range(0, 65535));
            wr(a, d);
         end else begin
            tick();
         end
      end

      // Asynchronous reset mid-period with a commit pending
      wr(A_PERIOD, 9);
      wr(A_CTRL, 3);
      wait_idle();
      wait_phase(4);
      wr(A_CTRL, 3);
      tick();
      tick();
      #2 rst = 1'b0;
      #1;
      chk("async_rst_pwm_out", 32'(pwm_out), 32'd0);
      chk("async_rst_pending", 32'(commit_pending), 32'd0);
      chk("async_rst_ready", 32'(bus.wr_ready), 32'd1);
      chk("async_rst_pstart", 32'(period_start), 32'd0);
      model_reset();
      repeat (2) tick();
      #2 rst = 1'b1;
      // Period must be back to all-ones: one high sample, no period_start
      wr(0, 1);
      wr(A_CTRL, 2);
      wait_idle();
      wr(A_CTRL, 1);
      hi0 = 0; ps = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         hi0 += int'(pwm_out[0]);
         ps  += int'(period_start);
      end
      chk("post_rst_ch0_high", 32'(hi0), 32'd1);
      chk("post_rst_no_wrap", 32'(ps), 32'd0);

      // Polarity on ch0
      wr(A_CTRL, 0);
      wr(A_PERIOD, 9);
      wr(0, 3);
      wr(A_POL, 1);
      wr(A_CTRL, 2);
      wait_idle();
      wr(A_CTRL, 1);
      hi0 = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         hi0 += int'(pwm_out[0]);
      end
      chk("pol_duty", 32'(hi0), POL_EN ? 32'd7 : 32'd3);
      wr(A_CTRL, 0);
      repeat (3) tick();
      chk("pol_disabled_level", 32'(pwm_out[0]), POL_EN ? 32'd1 : 32'd0);
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
